// File: rtl/intr_req_ctrl_if.sv
// Handshake bundle between the interrupt request conditioner and its neighbours:
// the button, the interrupt-enable flag and the control unit.
interface intr_req_ctrl_if #(
    parameter int unsigned MISS_W = 8
);
    logic              BTN_INT;
    logic              I_FLAG_OUT;
    logic              INT_ACK;
    logic              INTR;
    logic              INT_PENDING;
    logic [MISS_W-1:0] MISS_CNT;

    modport master (
        output BTN_INT,
        output I_FLAG_OUT,
        output INT_ACK,
        input  INTR,
        input  INT_PENDING,
        input  MISS_CNT
    );

    modport slave (
        input  BTN_INT,
        input  I_FLAG_OUT,
        input  INT_ACK,
        output INTR,
        output INT_PENDING,
        output MISS_CNT
    );
endinterface

// File: rtl/intr_req_ctrl.sv
// Interrupt request conditioner: synchronizes and debounces the interrupt button,
// latches one pending request per press and counts requests lost to an occupied latch.
module intr_req_ctrl #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_COUNT    = 500000,
    parameter int unsigned MISS_W      = 8
) (
    input logic              clk,
    input logic              RST,
    intr_req_ctrl_if.slave   bus
);
    localparam int unsigned CntW = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DB_COUNT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StDbPress,
        StHeld,
        StDbRelease
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    logic [CntW-1:0]        r_cnt;
    logic                   r_pending;
    logic [MISS_W-1:0]      r_miss;

    logic w_sync;
    logic w_accept;
    logic w_miss_sat;

    assign w_sync     = r_sync[SYNC_STAGES-1];
    // Combinational so the latch sets on the same edge the debounce completes.
    assign w_accept   = (r_state == StDbPress) && w_sync && (r_cnt == CntMax);
    assign w_miss_sat = &r_miss;

    always_ff @(posedge clk) begin
        if (RST) begin
            r_sync    <= '0;
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_pending <= 1'b0;
            r_miss    <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.BTN_INT};

            unique case (r_state)
                StIdle: begin
                    if (w_sync) begin
                        r_state <= StDbPress;
                        r_cnt   <= '0;
                    end
                end
                StDbPress: begin
                    if (!w_sync) begin
                        r_state <= StIdle;
                    end else if (r_cnt == CntMax) begin
                        r_state <= StHeld;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StHeld: begin
                    if (!w_sync) begin
                        r_state <= StDbRelease;
                        r_cnt   <= '0;
                    end
                end
                StDbRelease: begin
                    if (w_sync) begin
                        r_state <= StHeld;
                    end else if (r_cnt == CntMax) begin
                        r_state <= StIdle;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase

            // A new request outranks a same-cycle acknowledge and is not a miss.
            if (w_accept) begin
                r_pending <= 1'b1;
                if (r_pending && !bus.INT_ACK && !w_miss_sat) begin
                    r_miss <= r_miss + 1'b1;
                end
            end else if (bus.INT_ACK) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign bus.INT_PENDING = r_pending;
    assign bus.MISS_CNT    = r_miss;
    assign bus.INTR        = r_pending & bus.I_FLAG_OUT;
endmodule

// File: tb/tb_intr_req_ctrl.sv
// Directed bench for intr_req_ctrl with SYNC_STAGES=2, DB_COUNT=4, MISS_W=2.
module tb_intr_req_ctrl;
    localparam int unsigned SyncStages = 2;
    localparam int unsigned DbCount    = 4;
    localparam int unsigned MissW      = 2;

    typedef struct {
        string      name;
        logic       btn;
        logic       flag;
        logic       ack;
        int         n;
        logic       pend;
        logic       intr;
        logic [1:0] miss;
    } vec_t;

    logic clk = 1'b0;
    logic RST = 1'b0;
    int   errs   = 0;
    int   checks = 0;
    vec_t vecs[$];

    intr_req_ctrl_if #(.MISS_W(MissW)) bus();

    intr_req_ctrl #(
        .SYNC_STAGES(SyncStages),
        .DB_COUNT   (DbCount),
        .MISS_W     (MissW)
    ) dut (
        .clk(clk),
        .RST(RST),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic exp_pend, input logic exp_intr,
                       input logic [1:0] exp_miss);
        checks++;
        if (bus.INT_PENDING !== exp_pend) begin
            errs++;
            $display("FAIL %s INT_PENDING: got %b want %b", name, bus.INT_PENDING, exp_pend);
        end
        checks++;
        if (bus.INTR !== exp_intr) begin
            errs++;
            $display("FAIL %s INTR: got %b want %b", name, bus.INTR, exp_intr);
        end
        checks++;
        if (bus.MISS_CNT !== exp_miss) begin
            errs++;
            $display("FAIL %s MISS_CNT: got %0d want %0d", name, bus.MISS_CNT, exp_miss);
        end
    endtask

    function automatic void add(input string name, input logic btn, input logic flag,
                                input logic ack, input int n, input logic pend,
                                input logic intr, input logic [1:0] miss);
        vec_t v;
        v.name = name; v.btn = btn; v.flag = flag; v.ack = ack; v.n = n;
        v.pend = pend; v.intr = intr; v.miss = miss;
        vecs.push_back(v);
    endfunction

    // Full debounced press followed by a complete debounced release.
    task automatic press();
        bus.BTN_INT = 1'b1;
        tick(7);
        bus.BTN_INT = 1'b0;
        tick(10);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
    endtask

    initial begin
        bus.BTN_INT    = 1'b0;
        bus.I_FLAG_OUT = 1'b1;
        bus.INT_ACK    = 1'b0;

        // Reset held two cycles with the button pressed, then re-debounce.
        RST         = 1'b1;
        bus.BTN_INT = 1'b1;
        tick(2);
        chk("reset_hold", 1'b0, 1'b0, 2'd0);
        RST = 1'b0;
        tick(6);
        chk("post_reset_edge5", 1'b0, 1'b0, 2'd0);
        tick(1);
        chk("post_reset_edge6", 1'b1, 1'b1, 2'd0);
        bus.BTN_INT = 1'b0;
        bus.INT_ACK = 1'b1;
        tick(1);
        bus.INT_ACK = 1'b0;
        tick(10);
        chk("post_reset_cleared", 1'b0, 1'b0, 2'd0);

        //   name            btn   flag  ack   n   pend  intr  miss
        add("idle",          1'b0, 1'b1, 1'b0, 1,  1'b0, 1'b0, 2'd0);
        add("press_edge5",   1'b1, 1'b1, 1'b0, 6,  1'b0, 1'b0, 2'd0);
        add("press_edge6",   1'b1, 1'b1, 1'b0, 1,  1'b1, 1'b1, 2'd0);
        add("press_hold",    1'b1, 1'b1, 1'b0, 3,  1'b1, 1'b1, 2'd0);
        add("ack_clears",    1'b1, 1'b1, 1'b1, 1,  1'b0, 1'b0, 2'd0);
        add("held_no_new",   1'b1, 1'b1, 1'b0, 10, 1'b0, 1'b0, 2'd0);
        add("release_none",  1'b0, 1'b1, 1'b0, 10, 1'b0, 1'b0, 2'd0);
        add("ack_no_pend",   1'b0, 1'b1, 1'b1, 1,  1'b0, 1'b0, 2'd0);
        add("glitch_high",   1'b1, 1'b1, 1'b0, 3,  1'b0, 1'b0, 2'd0);
        add("glitch_low",    1'b0, 1'b1, 1'b0, 8,  1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 10; i++) begin
            add("bounce", ((i % 2) == 0) ? 1'b1 : 1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b0, 2'd0);
        end
        add("bounce_settle", 1'b0, 1'b1, 1'b0, 8,  1'b0, 1'b0, 2'd0);
        add("masked_press",  1'b1, 1'b0, 1'b0, 7,  1'b1, 1'b0, 2'd0);
        add("masked_wait",   1'b1, 1'b0, 1'b0, 5,  1'b1, 1'b0, 2'd0);
        add("unmask_comb",   1'b1, 1'b1, 1'b0, 0,  1'b1, 1'b1, 2'd0);
        add("unmask_ack",    1'b1, 1'b1, 1'b1, 1,  1'b0, 1'b0, 2'd0);
        add("unmask_rel",    1'b0, 1'b1, 1'b0, 10, 1'b0, 1'b0, 2'd0);

        foreach (vecs[i]) begin
            bus.BTN_INT    = vecs[i].btn;
            bus.I_FLAG_OUT = vecs[i].flag;
            bus.INT_ACK    = vecs[i].ack;
            tick(vecs[i].n);
            #1;
            chk(vecs[i].name, vecs[i].pend, vecs[i].intr, vecs[i].miss);
        end
        bus.INT_ACK    = 1'b0;
        bus.I_FLAG_OUT = 1'b1;

        // Second press while pending counts as a miss.
        press();
        chk("miss_first", 1'b1, 1'b1, 2'd0);
        press();
        chk("miss_second", 1'b1, 1'b1, 2'd1);

        // Accept coinciding with acknowledge: request survives, no miss.
        bus.BTN_INT = 1'b1;
        tick(6);
        bus.INT_ACK = 1'b1;
        tick(1);
        bus.INT_ACK = 1'b0;
        chk("collision", 1'b1, 1'b1, 2'd1);
        bus.BTN_INT = 1'b0;
        tick(10);
        bus.INT_ACK = 1'b1;
        tick(1);
        bus.INT_ACK = 1'b0;
        chk("ack_after_coll", 1'b0, 1'b0, 2'd1);

        // Saturation of the 2-bit miss counter.
        do_reset();
        chk("reset_pulse", 1'b0, 1'b0, 2'd0);
        press();
        chk("sat_base", 1'b1, 1'b1, 2'd0);
        for (int k = 1; k <= 5; k++) begin
            press();
            chk($sformatf("sat_extra%0d", k), 1'b1, 1'b1, (k > 3) ? 2'd3 : 2'(k));
        end

        // Reset with a request pending and a saturated counter.
        RST = 1'b1;
        tick(1);
        chk("reset_pending", 1'b0, 1'b0, 2'd0);
        RST = 1'b0;
        tick(10);
        chk("reset_pending_quiet", 1'b0, 1'b0, 2'd0);

        // Reset in the middle of the debounce; held button must fully re-qualify.
        bus.BTN_INT = 1'b1;
        tick(4);
        RST = 1'b1;
        tick(1);
        chk("reset_mid_db", 1'b0, 1'b0, 2'd0);
        RST = 1'b0;
        tick(6);
        chk("requal_edge5", 1'b0, 1'b0, 2'd0);
        tick(1);
        chk("requal_edge6", 1'b1, 1'b1, 2'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
